busn2m_pack: RTL

BUSN2M_PACK -- requirements
Module: busn2m_pack

---
 rtl/busn2m_pack.sv | 131 +++++++++++++
 1 files changed

// File: rtl/busn2m_pack.sv
// Narrow-to-wide blob packer: IN_WIDTH words gather in a COM_MUL staging register,
// partial last groups are zero-padded, then the stage drains as OUT_WIDTH words.
module busn2m_pack #(
  parameter int IN_WIDTH  = 96,
  parameter int OUT_WIDTH = 512,
  parameter int COM_MUL   = 1536,
  parameter int IN_COUNT  = COM_MUL / IN_WIDTH,
  parameter int OUT_COUNT = COM_MUL / OUT_WIDTH,
  parameter int N         = 320
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  blob_din,
  output logic                 blob_din_rdy,
  input  logic                 blob_din_en,
  input  logic                 blob_din_eop,
  output logic [OUT_WIDTH-1:0] blob_dout,
  input  logic                 blob_dout_rdy,
  output logic                 blob_dout_en,
  output logic                 blob_dout_eop
);

  localparam int CW = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1;
  localparam int OW = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
  localparam int TW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] IN_LAST = CW'(IN_COUNT - 1);
  localparam logic [TW-1:0] N_LAST  = TW'(N - 1);

  typedef enum logic [1:0] {FILL, PAD, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [COM_MUL-1:0]   stage_q, stage_d;
  logic [CW-1:0]        din_cnt_q, din_cnt_d;
  logic [TW-1:0]        din_total_q, din_total_d;
  logic [OW-1:0]        dout_cnt_q, dout_cnt_d;
  logic [OW-1:0]        drain_last_q, drain_last_d;
  logic                 last_grp_q, last_grp_d;

  logic                 accept;
  logic                 eob;
  logic [COM_MUL-1:0]   din_ext;

  // Index of the last output word for a group holding (k+1) input words.
  logic [OW-1:0] drain_last_tab [IN_COUNT];
  generate
    for (genvar gi = 0; gi < IN_COUNT; gi++) begin : g_len
      assign drain_last_tab[gi] = OW'(((gi + 1) * IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH - 1);
    end
  endgenerate

  assign blob_din_rdy  = (state_q == FILL);
  assign blob_dout_en  = (state_q == DRAIN) & blob_dout_rdy;
  assign blob_dout     = stage_q[OUT_WIDTH-1:0];
  assign blob_dout_eop = blob_dout_en & (dout_cnt_q == drain_last_q) & last_grp_q;

  assign accept  = blob_din_rdy & blob_din_en;
  assign eob     = accept & (blob_din_eop | (din_total_q == N_LAST));
  assign din_ext = COM_MUL'(blob_din);

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    din_cnt_d    = din_cnt_q;
    din_total_d  = din_total_q;
    dout_cnt_d   = dout_cnt_q;
    drain_last_d = drain_last_q;
    last_grp_d   = last_grp_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          // Shift-based insert also covers COM_MUL == IN_WIDTH (direct load).
          stage_d      = (stage_q >> IN_WIDTH) | (din_ext << (COM_MUL - IN_WIDTH));
          din_total_d  = eob ? '0 : din_total_q + TW'(1);
          drain_last_d = drain_last_tab[din_cnt_q];
          last_grp_d   = eob;
          if (din_cnt_q == IN_LAST) begin
            din_cnt_d = '0;
            state_d   = DRAIN;
          end else begin
            din_cnt_d = din_cnt_q + CW'(1);
            if (eob) state_d = PAD;
          end
        end
      end
      PAD: begin
        stage_d = stage_q >> IN_WIDTH;
        if (din_cnt_q == IN_LAST) begin
          din_cnt_d = '0;
          state_d   = DRAIN;
        end else begin
          din_cnt_d = din_cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (blob_dout_rdy) begin
          stage_d = stage_q >> OUT_WIDTH;
          if (dout_cnt_q == drain_last_q) begin
            dout_cnt_d = '0;
            stage_d    = '0;
            last_grp_d = 1'b0;
            state_d    = FILL;
          end else begin
            dout_cnt_d = dout_cnt_q + OW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      stage_q      <= '0;
      din_cnt_q    <= '0;
      din_total_q  <= '0;
      dout_cnt_q   <= '0;
      drain_last_q <= '0;
      last_grp_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      din_cnt_q    <= din_cnt_d;
      din_total_q  <= din_total_d;
      dout_cnt_q   <= dout_cnt_d;
      drain_last_q <= drain_last_d;
      last_grp_q   <= last_grp_d;
    end
  end

endmodule
